// File: rtl/game_pkg.sv
// Shared types and widths for the multi-player snake game session controller.
package game_pkg;
  localparam int LIVES_W  = 3;
  localparam int LEVEL_W  = 3;
  localparam int PLAYER_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_OVER   = 3'd3,
    ST_WON    = 3'd4
  } state_t;
endpackage

// File: rtl/game_player_slot.sv
// Per-player bookkeeping: lives, score, alive flag and the respawn sit-out counter.
module game_player_slot
  import game_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 8,
  parameter int WIN_SCORE     = 200,
  parameter int RESPAWN_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               run,
  input  logic               tick,
  input  logic               eat,
  input  logic               failure,
  input  logic               success,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               alive,
  output logic               respawn,
  output logic               busy,
  output logic               dying,
  output logic               win_hit
);
  localparam int RESP_W = $clog2(RESPAWN_TICKS + 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [RESP_W-1:0]  respawn_cnt;
  logic [SCORE_W-1:0] score_next;
  logic               eat_ok;
  logic               fail_ok;

  assign eat_ok     = run && alive && eat;
  assign fail_ok    = run && alive && failure;
  assign dying      = fail_ok && (lives == LIVES_W'(1));
  assign busy       = (respawn_cnt != '0);
  assign score_next = (eat_ok && score != SCORE_MAX) ? score + 1'b1 : score;
  // Score win is judged on the post-increment value so the winning apple counts.
  assign win_hit    = run && alive && (success || (eat_ok && 32'(score_next) >= WIN_SCORE));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      lives       <= LIVES_W'(LIVES);
      score       <= '0;
      alive       <= 1'b1;
      respawn_cnt <= '0;
      respawn     <= !rst;
    end else begin
      score   <= score_next;
      respawn <= 1'b0;
      if (fail_ok) begin
        if (lives > LIVES_W'(1)) begin
          lives       <= lives - 1'b1;
          respawn     <= 1'b1;
          respawn_cnt <= RESP_W'(RESPAWN_TICKS);
        end else begin
          lives <= '0;
          alive <= 1'b0;
        end
      end else if (run && tick && busy) begin
        respawn_cnt <= respawn_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/game_session.sv
// Game session controller: session FSM, shared apple/level tracking and one slot per player.
module game_session
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 8,
  parameter int WIN_SCORE     = 200,
  parameter int LEVEL_STEP    = 5,
  parameter int MAX_LEVEL     = 7,
  parameter int RESPAWN_TICKS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_restart,
  input  logic                           i_pause,
  input  logic [NUM_PLAYERS-1:0]         i_started,
  input  logic                           i_tick,
  input  logic                           i_apple_ready,
  input  logic [NUM_PLAYERS-1:0]         i_failure,
  input  logic [NUM_PLAYERS-1:0]         i_success,
  input  logic [NUM_PLAYERS-1:0]         i_eat,
  output logic [NUM_PLAYERS-1:0]         o_apply_tick,
  output logic [NUM_PLAYERS-1:0]         o_respawn,
  output logic [2:0]                     o_state,
  output logic [NUM_PLAYERS-1:0]         o_alive,
  output logic [NUM_PLAYERS*LIVES_W-1:0] o_lives,
  output logic [NUM_PLAYERS*SCORE_W-1:0] o_score,
  output logic [LEVEL_W-1:0]             o_level,
  output logic                           o_failure,
  output logic                           o_success,
  output logic [PLAYER_W-1:0]            o_winner
);
  localparam int APPLE_W = $clog2(LEVEL_STEP + NUM_PLAYERS + 1);

  state_t                  state, state_next;
  logic                    run;
  logic [NUM_PLAYERS-1:0]  alive, busy, dying, win_hit, eat_ok;
  logic [APPLE_W-1:0]      apple_cnt, eat_count, apple_sum;
  logic [LEVEL_W-1:0]      level;
  logic [PLAYER_W-1:0]     win_idx;

  assign run          = (state == ST_RUN);
  assign eat_ok       = i_eat & alive & {NUM_PLAYERS{run}};
  assign o_alive      = alive;
  assign o_level      = level;
  assign o_apply_tick = {NUM_PLAYERS{i_tick && run && i_apple_ready}} & alive & i_started & ~busy;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_slot
    game_player_slot #(
      .LIVES(LIVES), .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .RESPAWN_TICKS(RESPAWN_TICKS)
    ) u_slot (
      .clk(clk), .rst(rst), .restart(i_restart), .run(run), .tick(i_tick),
      .eat(i_eat[p]), .failure(i_failure[p]), .success(i_success[p]),
      .lives(o_lives[p*LIVES_W +: LIVES_W]), .score(o_score[p*SCORE_W +: SCORE_W]),
      .alive(alive[p]), .respawn(o_respawn[p]), .busy(busy[p]),
      .dying(dying[p]), .win_hit(win_hit[p])
    );
  end

  // Simultaneous eats all count toward the shared level progress.
  always_comb begin
    eat_count = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) eat_count = eat_count + APPLE_W'(eat_ok[p]);
    apple_sum = apple_cnt + eat_count;
  end

  always_comb begin
    win_idx = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) if (win_hit[p]) win_idx = PLAYER_W'(p);
  end

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      apple_cnt <= '0;
      level     <= '0;
      o_winner  <= '0;
    end else begin
      if (apple_sum >= APPLE_W'(LEVEL_STEP)) begin
        apple_cnt <= apple_sum - APPLE_W'(LEVEL_STEP);
        if (level < LEVEL_W'(MAX_LEVEL)) level <= level + 1'b1;
      end else begin
        apple_cnt <= apple_sum;
      end
      if (run && (|win_hit)) o_winner <= win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_restart) state <= ST_IDLE;
    else                  state <= state_next;
  end

  // A win outranks the whole field dying in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if ((|i_started) && i_apple_ready) state_next = ST_RUN;
      ST_RUN: begin
        if (|win_hit)                 state_next = ST_WON;
        else if (&(~alive | dying))   state_next = ST_OVER;
        else if (i_pause)             state_next = ST_PAUSED;
      end
      ST_PAUSED: if (!i_pause) state_next = ST_RUN;
      default:   state_next = state;
    endcase
  end

  always_comb begin
    o_state   = state;
    o_failure = (state == ST_OVER);
    o_success = (state == ST_WON);
  end
endmodule

// File: tb/tb_game_session.sv
// Directed bench for game_session: a one-player and a two-player instance checked via a scoreboard queue.
module tb_game_session;
  import game_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_restart, a_pause, a_tick, a_apple;
  logic [0:0] a_started, a_fail, a_succ, a_eat, a_apply, a_respawn, a_alive;
  logic [2:0] a_state, a_lives, a_level;
  logic [7:0] a_score;
  logic       a_failure, a_success;
  logic [1:0] a_winner;

  logic        b_restart, b_pause, b_tick, b_apple;
  logic [1:0]  b_started, b_fail, b_succ, b_eat, b_apply, b_respawn, b_alive;
  logic [2:0]  b_state, b_level;
  logic [5:0]  b_lives;
  logic [15:0] b_score;
  logic        b_failure, b_success;
  logic [1:0]  b_winner;

  game_session #(.NUM_PLAYERS(1)) dut_a (
    .clk(clk), .rst(rst), .i_restart(a_restart), .i_pause(a_pause), .i_started(a_started),
    .i_tick(a_tick), .i_apple_ready(a_apple), .i_failure(a_fail), .i_success(a_succ), .i_eat(a_eat),
    .o_apply_tick(a_apply), .o_respawn(a_respawn), .o_state(a_state), .o_alive(a_alive),
    .o_lives(a_lives), .o_score(a_score), .o_level(a_level), .o_failure(a_failure),
    .o_success(a_success), .o_winner(a_winner)
  );

  game_session dut_b (
    .clk(clk), .rst(rst), .i_restart(b_restart), .i_pause(b_pause), .i_started(b_started),
    .i_tick(b_tick), .i_apple_ready(b_apple), .i_failure(b_fail), .i_success(b_succ), .i_eat(b_eat),
    .o_apply_tick(b_apply), .o_respawn(b_respawn), .o_state(b_state), .o_alive(b_alive),
    .o_lives(b_lives), .o_score(b_score), .o_level(b_level), .o_failure(b_failure),
    .o_success(b_success), .o_winner(b_winner)
  );

  localparam int A_STATE = 0, A_LIVES = 1, A_RESPAWN = 2, A_APPLY = 3, A_ALIVE = 4,
                 A_FAILURE = 5, A_SCORE = 6, A_RESPCNT = 7, B_STATE = 8, B_LIVES = 9,
                 B_ALIVE = 10, B_SCORE = 11, B_LEVEL = 12, B_WINNER = 13, B_RESPAWN = 14,
                 B_APPLY = 15, B_SUCCESS = 16, B_FAILURE = 17;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   a_resp_pulses = 0;

  // Respawn pulses span a full cycle, so each one is seen by exactly one falling edge.
  always @(negedge clk) if (a_respawn[0] === 1'b1) a_resp_pulses++;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      A_STATE:   return 32'(a_state);
      A_LIVES:   return 32'(a_lives);
      A_RESPAWN: return 32'(a_respawn);
      A_APPLY:   return 32'(a_apply);
      A_ALIVE:   return 32'(a_alive);
      A_FAILURE: return 32'(a_failure);
      A_SCORE:   return 32'(a_score);
      A_RESPCNT: return 32'(a_resp_pulses);
      B_STATE:   return 32'(b_state);
      B_LIVES:   return 32'(b_lives);
      B_ALIVE:   return 32'(b_alive);
      B_SCORE:   return 32'(b_score);
      B_LEVEL:   return 32'(b_level);
      B_WINNER:  return 32'(b_winner);
      B_RESPAWN: return 32'(b_respawn);
      B_APPLY:   return 32'(b_apply);
      B_SUCCESS: return 32'(b_success);
      B_FAILURE: return 32'(b_failure);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    sb.push_back('{tag, sel, exp});
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s got %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic a_tick_pulse();
    a_tick = 1'b1;
    applyStimulus(1);
    a_tick = 1'b0;
    applyStimulus(1);
  endtask

  initial begin
    rst = 1'b1;
    a_restart = 0; a_pause = 0; a_tick = 0; a_apple = 0;
    a_started = 0; a_fail = 0; a_succ = 0; a_eat = 0;
    b_restart = 0; b_pause = 0; b_tick = 0; b_apple = 0;
    b_started = 0; b_fail = 0; b_succ = 0; b_eat = 0;
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(1);
    $display("[TB] reset state");
    expect_val("rst_a_state", A_STATE, ST_IDLE);
    expect_val("rst_a_lives", A_LIVES, 3);
    expect_val("rst_a_respawn", A_RESPAWN, 0);
    expect_val("rst_b_lives", B_LIVES, 6'b011_011);
    expect_val("rst_b_alive", B_ALIVE, 2'b11);
    expect_val("rst_b_score", B_SCORE, 0);
    expect_val("rst_b_level", B_LEVEL, 0);
    expect_val("rst_b_winner", B_WINNER, 0);
    checkOutput();

    $display("[TB] single player lives run-down");
    a_started = 1; a_apple = 1;
    applyStimulus(1);
    expect_val("a_start", A_STATE, ST_RUN);
    checkOutput();
    a_fail = 1;
    applyStimulus(1);
    a_fail = 0;
    expect_val("a_fail1_lives", A_LIVES, 2);
    expect_val("a_fail1_respawn", A_RESPAWN, 1);
    checkOutput();
    applyStimulus(1);
    expect_val("a_respawn_one_cycle", A_RESPAWN, 0);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      a_tick = 1; #1;
      expect_val("a_sitout_tick", A_APPLY, 0);
      checkOutput();
      applyStimulus(1);
      a_tick = 0;
      applyStimulus(1);
    end
    a_tick = 1; #1;
    expect_val("a_resume_tick", A_APPLY, 1);
    checkOutput();
    applyStimulus(1);
    a_tick = 0;
    for (int i = 0; i < 5; i++) a_tick_pulse();
    a_fail = 1;
    applyStimulus(1);
    a_fail = 0;
    expect_val("a_fail2_lives", A_LIVES, 1);
    expect_val("a_fail2_respawn", A_RESPAWN, 1);
    expect_val("a_fail2_state", A_STATE, ST_RUN);
    checkOutput();
    for (int i = 0; i < 10; i++) a_tick_pulse();
    a_fail = 1;
    applyStimulus(1);
    a_fail = 0;
    expect_val("a_fail3_lives", A_LIVES, 0);
    expect_val("a_fail3_alive", A_ALIVE, 0);
    expect_val("a_fail3_state", A_STATE, ST_OVER);
    expect_val("a_fail3_flag", A_FAILURE, 1);
    expect_val("a_fail3_no_respawn", A_RESPAWN, 0);
    expect_val("a_respawn_pulses", A_RESPCNT, 2);
    checkOutput();
    a_eat = 1;
    applyStimulus(1);
    a_eat = 0;
    expect_val("a_over_eat_ignored", A_SCORE, 0);
    expect_val("a_over_terminal", A_STATE, ST_OVER);
    checkOutput();
    a_started = 0; a_restart = 1;
    applyStimulus(1);
    a_restart = 0;
    expect_val("a_restart_state", A_STATE, ST_IDLE);
    expect_val("a_restart_respawn", A_RESPAWN, 1);
    expect_val("a_restart_lives", A_LIVES, 3);
    checkOutput();

    $display("[TB] two players: apples and levels");
    b_started = 2'b11; b_apple = 1;
    applyStimulus(1);
    expect_val("b_start", B_STATE, ST_RUN);
    checkOutput();
    b_eat = 2'b01;
    applyStimulus(4);
    b_eat = 0;
    expect_val("b_four_apples_level", B_LEVEL, 0);
    expect_val("b_four_apples_score", B_SCORE, 16'h0004);
    checkOutput();
    b_eat = 2'b11;
    applyStimulus(1);
    b_eat = 0;
    expect_val("b_double_eat_level", B_LEVEL, 1);
    expect_val("b_double_eat_score", B_SCORE, 16'h0105);
    checkOutput();
    b_eat = 2'b10;
    applyStimulus(3);
    expect_val("b_carry_level_hold", B_LEVEL, 1);
    checkOutput();
    applyStimulus(1);
    b_eat = 0;
    expect_val("b_carry_level_next", B_LEVEL, 2);
    expect_val("b_carry_score", B_SCORE, 16'h0505);
    checkOutput();

    $display("[TB] pause");
    b_pause = 1;
    applyStimulus(1);
    expect_val("b_paused", B_STATE, ST_PAUSED);
    checkOutput();
    b_tick = 1; b_fail = 2'b01; b_eat = 2'b11; b_succ = 2'b10; #1;
    expect_val("b_paused_apply", B_APPLY, 0);
    checkOutput();
    applyStimulus(1);
    b_tick = 0; b_fail = 0; b_eat = 0; b_succ = 0;
    expect_val("b_paused_state", B_STATE, ST_PAUSED);
    expect_val("b_paused_lives", B_LIVES, 6'b011_011);
    expect_val("b_paused_score", B_SCORE, 16'h0505);
    checkOutput();
    b_pause = 0;
    applyStimulus(1);
    expect_val("b_unpause_state", B_STATE, ST_RUN);
    expect_val("b_unpause_lives", B_LIVES, 6'b011_011);
    checkOutput();
    b_started = 2'b01; b_tick = 1; #1;
    expect_val("b_unpause_apply", B_APPLY, 2'b01);
    checkOutput();
    applyStimulus(1);
    b_tick = 0; b_started = 2'b11;

    b_eat = 2'b11;
    applyStimulus(16);
    b_eat = 0;
    expect_val("b_level_saturate", B_LEVEL, 7);
    expect_val("b_level_sat_score", B_SCORE, 16'h1515);
    checkOutput();

    $display("[TB] win vs final failure");
    b_fail = 2'b01;
    applyStimulus(1);
    expect_val("b_p0_fail1_lives", B_LIVES, 6'b011_010);
    expect_val("b_p0_fail1_respawn", B_RESPAWN, 2'b01);
    checkOutput();
    applyStimulus(1);
    expect_val("b_p0_fail2_lives", B_LIVES, 6'b011_001);
    checkOutput();
    b_succ = 2'b10;
    applyStimulus(1);
    b_fail = 0; b_succ = 0;
    expect_val("b_win_state", B_STATE, ST_WON);
    expect_val("b_win_winner", B_WINNER, 1);
    expect_val("b_win_success", B_SUCCESS, 1);
    expect_val("b_win_failure", B_FAILURE, 0);
    expect_val("b_win_lives", B_LIVES, 6'b011_000);
    expect_val("b_win_alive", B_ALIVE, 2'b10);
    checkOutput();
    b_fail = 2'b11;
    applyStimulus(1);
    b_fail = 0;
    expect_val("b_won_terminal", B_STATE, ST_WON);
    expect_val("b_won_fail_ignored", B_LIVES, 6'b011_000);
    checkOutput();

    b_restart = 1;
    applyStimulus(1);
    b_restart = 0;
    expect_val("b_restart_won_state", B_STATE, ST_IDLE);
    expect_val("b_restart_won_winner", B_WINNER, 0);
    expect_val("b_restart_won_respawn", B_RESPAWN, 2'b11);
    expect_val("b_restart_won_level", B_LEVEL, 0);
    checkOutput();
    applyStimulus(1);
    expect_val("b_rerun_state", B_STATE, ST_RUN);
    expect_val("b_rerun_respawn", B_RESPAWN, 0);
    checkOutput();
    b_succ = 2'b11;
    applyStimulus(1);
    b_succ = 0;
    expect_val("b_tie_state", B_STATE, ST_WON);
    expect_val("b_tie_winner", B_WINNER, 0);
    checkOutput();

    b_restart = 1;
    applyStimulus(1);
    b_restart = 0;
    applyStimulus(1);
    b_fail = 2'b11;
    applyStimulus(2);
    expect_val("b_both_low_lives", B_LIVES, 6'b001_001);
    checkOutput();
    b_succ = 2'b10;
    applyStimulus(1);
    b_fail = 0; b_succ = 0;
    expect_val("b_won_over_priority", B_STATE, ST_WON);
    expect_val("b_won_over_winner", B_WINNER, 1);
    expect_val("b_won_over_alive", B_ALIVE, 0);
    checkOutput();

    $display("[TB] game over and restart");
    b_restart = 1;
    applyStimulus(1);
    b_restart = 0;
    applyStimulus(1);
    b_eat = 2'b11;
    applyStimulus(1);
    b_eat = 0;
    b_fail = 2'b11;
    applyStimulus(3);
    b_fail = 0;
    expect_val("b_over_state", B_STATE, ST_OVER);
    expect_val("b_over_flag", B_FAILURE, 1);
    expect_val("b_over_alive", B_ALIVE, 0);
    expect_val("b_over_lives", B_LIVES, 0);
    expect_val("b_over_score", B_SCORE, 16'h0101);
    checkOutput();
    b_started = 0; b_restart = 1;
    applyStimulus(1);
    b_restart = 0;
    expect_val("b_restart_over_state", B_STATE, ST_IDLE);
    expect_val("b_restart_over_respawn", B_RESPAWN, 2'b11);
    expect_val("b_restart_over_lives", B_LIVES, 6'b011_011);
    expect_val("b_restart_over_score", B_SCORE, 0);
    checkOutput();
    applyStimulus(1);
    expect_val("b_restart_pulse_end", B_RESPAWN, 0);
    expect_val("b_idle_hold", B_STATE, ST_IDLE);
    checkOutput();

    $display("[TB] score win");
    b_started = 2'b11;
    applyStimulus(1);
    b_eat = 2'b10;
    applyStimulus(199);
    expect_val("b_score_199_state", B_STATE, ST_RUN);
    expect_val("b_score_199", B_SCORE, 16'hC700);
    checkOutput();
    applyStimulus(1);
    b_eat = 0;
    expect_val("b_score_win_state", B_STATE, ST_WON);
    expect_val("b_score_win_winner", B_WINNER, 1);
    expect_val("b_score_win_score", B_SCORE, 16'hC800);
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
